z80_alu_ctl: RTL and testbench
==============================

# z80_alu_ctl

Sequencer on the initiating side of the Z80 ALU. It decodes one 8-bit ALU-group or CB-prefixed opcode and selects operands from the register read port, or from memory for the (HL) form. It drives the ALU command and operand lines, captures the result and flags, and issues register, flag and memory writeback. It sits between the instruction decoder, which pulses `start`, and the combinational ALU, the register file and the memory bus.

## Interface
- No parameters.
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request; sampled only when `busy`=0.
- `cb` in 1: opcode is CB-prefixed.
- `opcode` in 8: opcode byte, valid with `start`.
- `imm` in 8: immediate operand, valid with `start`.
- `a`, `f` in 8 each: current A and F.
- `hl` in 16: current HL.
- `src_sel` out 3: register read-port index (0=B,1=C,2=D,3=E,4=H,5=L,7=A).
- `src_val` in 8: register read data, combinational from `src_sel`.
- `alu_m` out 5: ALU command.
- `alu_op1`, `alu_op2` out 8 each: ALU operands.
- `alu_r` in 9: ALU result.
- `alu_f` in 8: ALU flags.
- `mem_addr` out 16: memory address.
- `mem_rd`, `mem_wr` out 1 each: memory strobes.
- `mem_wdata` out 8: memory write data.
- `mem_rdata` in 8: memory read data.
- `mem_ready` in 1: completes the current memory access.
- `wb_en` out 1, `wb_sel` out 3, `wb_data` out 8: register writeback.
- `f_en` out 1, `f_out` out 8: flag writeback.
- `busy` out 1, `done` out 1, `illegal` out 1: status.

## Operation
- Decode is latched on accepted `start`. Field `s`=opcode[2:0] selects the source (6 means (HL)). Field `y`=opcode[5:3].
- Non-CB 10yyysss:
  - `alu_m` by `y`: ADD, ADC, SUB, SBC, AND, XOR, OR, CP.
  - op1=`a`, op2=source.
  - Writes A (`wb_sel`=7) unless CP. `f_en`=1.
- Non-CB 11yyy110: same group, op2=`imm` (see Configuration).
- CB 00yyysss: `alu_m` by `y`: RLC, RRC, RL, RR, SLA, SRA, SLL, SRL. op1=source. Result is written to the source (register or (HL)). `f_en`=1.
- CB 01bbbsss (BIT): op1=source, op2={5'b0,b}. `f_en`=1, no data writeback.
- CB 10bbbsss / 11bbbsss (RES/SET): op2={4'b0,opcode[6],b}. Result is written back. `f_en`=0.
- Any other opcode: `illegal`=1 for one cycle with `done`. No register, flag or memory writes.
- `f_out`=captured `alu_f`. `wb_data`/`mem_wdata`=captured `alu_r[7:0]`.
- States:
  - IDLE: on `start` go to FETCH if s=6 and the opcode is legal, else EXEC. An illegal opcode goes to DONE.
  - FETCH: `mem_rd`=1, `mem_addr`=`hl`. Latch `mem_rdata` on `mem_ready`, then go to EXEC.
  - EXEC: ALU lines driven from registered operands; capture `alu_r`/`alu_f` at the clock edge. Go to WRITE if this is a CB (HL) op other than BIT, else DONE.
  - WRITE: `mem_wr`=1, `mem_addr`=`hl`. Leave on `mem_ready`.
  - DONE: `done`=1 and `wb_en`/`f_en` pulsed for one cycle, then IDLE.
- `busy`=1 in every state except IDLE. `start` while busy is ignored and not queued.

## Timing
- Reset values: every output 0; state IDLE.
- Register source: `start` in cycle 0, EXEC in cycle 1, `done` in cycle 2.
- (HL) read: each FETCH/WRITE wait cycle (`mem_ready`=0) adds one cycle.
  - Minimum for an (HL) read-modify-write: `done` in cycle 4.
  - Minimum for BIT (HL) or an 8-bit ALU (HL) op: `done` in cycle 3.
- `mem_rd`/`mem_wr` are held stable with `mem_addr` until `mem_ready`; they are never asserted together.
- `mem_ready` outside FETCH/WRITE is ignored.
- `hl`, `a` and `f` are sampled at `start`; later changes do not affect the op.
- Reset mid-operation forces IDLE and clears all strobes immediately; no partial writeback occurs.
- `start` coincident with DONE is ignored, because `busy`=1 in DONE.

## Configuration
- `ALU_CTL_IMM_EN` defined: 11yyy110 executes with op2=`imm`.
- Not defined: 11yyy110 is illegal, and `imm` is unused.

## Structure
- Shared package/header holds:
  - `ALU_*` command codes (shared with the ALU).
  - Flag bit indices (`CARRY`, `NEG`, `PARITY`, `AUX`, `ZERO`, `SIGN`).
  - State encoding.
  - Register index constants.
- One natural sub-module: `z80_alu_dec`, the combinational opcode to {alu_m, op2 kind, writeback kind, mem, illegal} decoder.

## Test plan
- ADD A,B with A=3Ah, B=C6h: `done` in cycle 2 with `wb_sel`=7, `wb_data`=00h, `f_out`=51h.
- CP B with A=10h, B=20h: `f_en`=1, `f_out`=A3h, `wb_en`=0.
- CB SET 7,(HL) with HL=8000h and memory 01h, `mem_ready` low for 2 cycles in FETCH: read of 8000h, then write of 81h to 8000h. `f_en`=0; `done` in cycle 6.
- CB BIT 0,C with C=00h: `f_out`=54h, `f_en`=1, `wb_en`=0.
- Reset asserted during FETCH: `mem_rd`=0 at once, `busy`=0, and no `done`/`wb_en`/`f_en`. A following ADD completes normally.
- Non-CB 00h: `illegal`=1 and `done`=1 in cycle 1 with no writes. A second `start` while busy is ignored.
- Run the bench with and without `ALU_CTL_IMM_EN`. Opcode C6h with `imm`=01h and A=FFh gives A=00h and `f_out`=51h when defined, and `illegal`=1 when not.

Source files
------------

// File: rtl/z80_alu_ctl_pkg.sv
// ============================================================================
// z80_alu_ctl_pkg : ALU command codes, flag indices, states and decode record
// Revision 1.0
// ============================================================================
`default_nettype none

package z80_alu_ctl_pkg;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_ADC = 5'd1;
   localparam logic [4:0] ALU_SUB = 5'd2;
   localparam logic [4:0] ALU_SBC = 5'd3;
   localparam logic [4:0] ALU_AND = 5'd4;
   localparam logic [4:0] ALU_XOR = 5'd5;
   localparam logic [4:0] ALU_OR  = 5'd6;
   localparam logic [4:0] ALU_CP  = 5'd7;
   localparam logic [4:0] ALU_RLC = 5'd8;
   localparam logic [4:0] ALU_RRC = 5'd9;
   localparam logic [4:0] ALU_RL  = 5'd10;
   localparam logic [4:0] ALU_RR  = 5'd11;
   localparam logic [4:0] ALU_SLA = 5'd12;
   localparam logic [4:0] ALU_SRA = 5'd13;
   localparam logic [4:0] ALU_SLL = 5'd14;
   localparam logic [4:0] ALU_SRL = 5'd15;
   localparam logic [4:0] ALU_BIT = 5'd16;
   localparam logic [4:0] ALU_RES = 5'd17;
   localparam logic [4:0] ALU_SET = 5'd18;

   localparam int CARRY  = 0;
   localparam int NEG    = 1;
   localparam int PARITY = 2;
   localparam int AUX    = 4;
   localparam int ZERO   = 6;
   localparam int SIGN   = 7;

   localparam logic [2:0] REG_B  = 3'd0;
   localparam logic [2:0] REG_C  = 3'd1;
   localparam logic [2:0] REG_D  = 3'd2;
   localparam logic [2:0] REG_E  = 3'd3;
   localparam logic [2:0] REG_H  = 3'd4;
   localparam logic [2:0] REG_L  = 3'd5;
   localparam logic [2:0] REG_HL = 3'd6;
   localparam logic [2:0] REG_A  = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      OP2_CONST = 2'd0,
      OP2_SRC   = 2'd1,
      OP2_IMM   = 2'd2
   } op2_kind_e;

   typedef struct packed {
      logic [4:0] alu_m;
      op2_kind_e  op2_kind;
      logic [7:0] op2_const;
      logic       src_op2;    // source feeds op2 (A is op1), else source is op1
      logic       mem_src;
      logic       wr_reg;
      logic       wr_mem;
      logic       wr_flags;
      logic [2:0] wb_sel;
      logic       illegal;
   } dec_t;

endpackage

`default_nettype wire

// File: rtl/z80_alu_dec.sv
// ============================================================================
// z80_alu_dec : combinational opcode decoder; ALU_CTL_IMM_EN enables 11yyy110
// Revision 1.0
// ============================================================================
`default_nettype none

module z80_alu_dec
   import z80_alu_ctl_pkg::*;
(
   input  logic       cb,
   input  logic [7:0] opcode,
   output dec_t       dec
);

   logic [2:0] w_s;
   logic [2:0] w_y;
   logic       w_hl;

   assign w_s  = opcode[2:0];
   assign w_y  = opcode[5:3];
   assign w_hl = (w_s == REG_HL);

   always_comb begin
      dec          = '0;
      dec.op2_kind = OP2_CONST;
      if (!cb) begin
         if (opcode[7:6] == 2'b10) begin
            dec.alu_m    = {2'b00, w_y};
            dec.op2_kind = OP2_SRC;
            dec.src_op2  = 1'b1;
            dec.mem_src  = w_hl;
            dec.wr_reg   = (w_y != 3'd7);
            dec.wr_flags = 1'b1;
            dec.wb_sel   = REG_A;
         end
`ifdef ALU_CTL_IMM_EN
         else if (opcode[7:6] == 2'b11 && w_hl) begin
            dec.alu_m    = {2'b00, w_y};
            dec.op2_kind = OP2_IMM;
            dec.src_op2  = 1'b1;
            dec.wr_reg   = (w_y != 3'd7);
            dec.wr_flags = 1'b1;
            dec.wb_sel   = REG_A;
         end
`endif
         else begin
            dec.illegal = 1'b1;
         end
      end else begin
         dec.mem_src = w_hl;
         dec.wb_sel  = w_s;
         case (opcode[7:6])
            2'b00: begin
               dec.alu_m    = {2'b01, w_y};
               dec.wr_reg   = !w_hl;
               dec.wr_mem   = w_hl;
               dec.wr_flags = 1'b1;
            end
            2'b01: begin
               dec.alu_m     = ALU_BIT;
               dec.op2_const = {5'b0, w_y};
               dec.wr_flags  = 1'b1;
            end
            default: begin
               // op2 bit 3 distinguishes SET from RES for the ALU
               dec.alu_m     = opcode[6] ? ALU_SET : ALU_RES;
               dec.op2_const = {4'b0, opcode[6], w_y};
               dec.wr_reg    = !w_hl;
               dec.wr_mem    = w_hl;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/z80_alu_ctl.sv
// ============================================================================
// z80_alu_ctl : ALU sequencer (operand fetch, execute, writeback); ALU_CTL_IMM_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module z80_alu_ctl
   import z80_alu_ctl_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        cb,
   input  logic [7:0]  opcode,
   input  logic [7:0]  imm,
   input  logic [7:0]  a,
   input  logic [7:0]  f,
   input  logic [15:0] hl,
   output logic [2:0]  src_sel,
   input  logic [7:0]  src_val,
   output logic [4:0]  alu_m,
   output logic [7:0]  alu_op1,
   output logic [7:0]  alu_op2,
   input  logic [8:0]  alu_r,
   input  logic [7:0]  alu_f,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic        wb_en,
   output logic [2:0]  wb_sel,
   output logic [7:0]  wb_data,
   output logic        f_en,
   output logic [7:0]  f_out,
   output logic        busy,
   output logic        done,
   output logic        illegal
);

   state_e      r_state;
   state_e      w_next;
   dec_t        w_dec;
   logic        w_accept;
   logic [7:0]  w_op2_init;
   logic        w_unused;

   logic [4:0]  r_alu_m;
   logic        r_src_op2;
   logic        r_wr_reg;
   logic        r_wr_mem;
   logic        r_wr_flags;
   logic        r_illegal;
   logic [2:0]  r_wb_sel;
   logic [15:0] r_hl;
   logic [7:0]  r_op1;
   logic [7:0]  r_op2;
   logic [7:0]  r_res;
   logic [7:0]  r_flags;

   z80_alu_dec u_dec (
      .cb     (cb),
      .opcode (opcode),
      .dec    (w_dec)
   );

   // F reaches the ALU directly from the register file; carry-out lives in alu_f
   assign w_unused = ^{f, alu_r[8]};

   assign w_accept = (r_state == ST_IDLE) && start;
   assign src_sel  = w_accept ? opcode[2:0] : 3'd0;

   always_comb begin
      case (w_dec.op2_kind)
         OP2_SRC: w_op2_init = src_val;
         OP2_IMM: w_op2_init = imm;
         default: w_op2_init = w_dec.op2_const;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_alu_m    <= 5'd0;
         r_src_op2  <= 1'b0;
         r_wr_reg   <= 1'b0;
         r_wr_mem   <= 1'b0;
         r_wr_flags <= 1'b0;
         r_illegal  <= 1'b0;
         r_wb_sel   <= 3'd0;
         r_hl       <= 16'd0;
         r_op1      <= 8'd0;
         r_op2      <= 8'd0;
         r_res      <= 8'd0;
         r_flags    <= 8'd0;
      end else begin
         if (w_accept) begin
            r_alu_m    <= w_dec.alu_m;
            r_src_op2  <= w_dec.src_op2;
            r_wr_reg   <= w_dec.wr_reg;
            r_wr_mem   <= w_dec.wr_mem;
            r_wr_flags <= w_dec.wr_flags;
            r_illegal  <= w_dec.illegal;
            r_wb_sel   <= w_dec.wb_sel;
            r_hl       <= hl;
            r_op1      <= w_dec.src_op2 ? a : src_val;
            r_op2      <= w_op2_init;
         end
         if (r_state == ST_FETCH && mem_ready) begin
            if (r_src_op2) r_op2 <= mem_rdata;
            else           r_op1 <= mem_rdata;
         end
         if (r_state == ST_EXEC) begin
            r_res   <= alu_r[7:0];
            r_flags <= alu_f;
         end
      end
   end

   always_comb begin
      w_next   = r_state;
      busy     = 1'b1;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      mem_addr = 16'd0;
      done     = 1'b0;
      wb_en    = 1'b0;
      f_en     = 1'b0;
      illegal  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (w_dec.illegal)      w_next = ST_DONE;
               else if (w_dec.mem_src) w_next = ST_FETCH;
               else                    w_next = ST_EXEC;
            end
         end
         ST_FETCH: begin
            mem_rd   = 1'b1;
            mem_addr = r_hl;
            if (mem_ready) w_next = ST_EXEC;
         end
         ST_EXEC: begin
            w_next = r_wr_mem ? ST_WRITE : ST_DONE;
         end
         ST_WRITE: begin
            mem_wr   = 1'b1;
            mem_addr = r_hl;
            if (mem_ready) w_next = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            wb_en   = r_wr_reg;
            f_en    = r_wr_flags;
            illegal = r_illegal;
            w_next  = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign alu_m     = r_alu_m;
   assign alu_op1   = r_op1;
   assign alu_op2   = r_op2;
   assign wb_sel    = r_wb_sel;
   assign wb_data   = r_res;
   assign mem_wdata = r_res;
   assign f_out     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_z80_alu_ctl.sv
// ============================================================================
// tb_z80_alu_ctl : directed-vector bench for z80_alu_ctl (with an ALU/memory model)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_z80_alu_ctl;
   import z80_alu_ctl_pkg::*;

   logic        clock = 1'b0;
   logic        reset, start, cb;
   logic [7:0]  opcode, imm, a, f;
   logic [15:0] hl;
   logic [2:0]  src_sel;
   logic [7:0]  src_val;
   logic [4:0]  alu_m;
   logic [7:0]  alu_op1, alu_op2;
   logic [8:0]  alu_r;
   logic [7:0]  alu_f;
   logic [15:0] mem_addr;
   logic        mem_rd, mem_wr, mem_ready;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        wb_en, f_en, busy, done, illegal;
   logic [2:0]  wb_sel;
   logic [7:0]  wb_data, f_out;

   logic [7:0]  regs [0:7];
   logic [7:0]  f_ref;
   logic [7:0]  mem_byte;
   int          rd_wait, wr_wait;
   int          rd_cnt, wr_cnt;
   int          strobe_cnt, overlap_cnt, mem_wr_cnt;
   logic [15:0] last_raddr, last_waddr;
   logic [7:0]  last_wdata;
   int          n_checks, n_errors;

   always #5 clock = ~clock;

   z80_alu_ctl dut (
      .clock(clock), .reset(reset), .start(start), .cb(cb), .opcode(opcode),
      .imm(imm), .a(a), .f(f), .hl(hl), .src_sel(src_sel), .src_val(src_val),
      .alu_m(alu_m), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_r(alu_r),
      .alu_f(alu_f), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .f_en(f_en),
      .f_out(f_out), .busy(busy), .done(done), .illegal(illegal)
   );

   // Reference Z80 ALU: {flags, result}
   function automatic logic [16:0] alu_model(input logic [4:0] m, input logic [7:0] x,
                                             input logic [7:0] y, input logic [7:0] fi);
      logic [8:0] r;
      logic [7:0] fl;
      logic [4:0] hn;
      logic       cin;
      logic [7:0] mask;
      r    = 9'd0;
      fl   = fi;
      mask = 8'd1 << y[2:0];
      case (m)
         ALU_ADD, ALU_ADC: begin
            cin = (m == ALU_ADC) & fi[CARRY];
            r   = {1'b0, x} + {1'b0, y} + {8'd0, cin};
            hn  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, cin};
            fl  = {r[7], r[7:0] == 8'd0, r[5], hn[4], r[3],
                   (x[7] == y[7]) && (r[7] != x[7]), 1'b0, r[8]};
         end
         ALU_SUB, ALU_SBC, ALU_CP: begin
            cin = (m == ALU_SBC) & fi[CARRY];
            r   = {1'b0, x} - {1'b0, y} - {8'd0, cin};
            hn  = {1'b0, x[3:0]} - {1'b0, y[3:0]} - {4'd0, cin};
            fl  = {r[7], r[7:0] == 8'd0, (m == ALU_CP) ? y[5] : r[5], hn[4],
                   (m == ALU_CP) ? y[3] : r[3], (x[7] != y[7]) && (r[7] != x[7]), 1'b1, r[8]};
         end
         ALU_AND, ALU_XOR, ALU_OR: begin
            r[7:0] = (m == ALU_AND) ? (x & y) : (m == ALU_XOR) ? (x ^ y) : (x | y);
            fl     = {r[7], r[7:0] == 8'd0, r[5], m == ALU_AND, r[3], ~^r[7:0], 1'b0, 1'b0};
         end
         ALU_RLC: begin
            r[7:0] = {x[6:0], x[7]};
            fl     = {r[7], r[7:0] == 8'd0, r[5], 1'b0, r[3], ~^r[7:0], 1'b0, x[7]};
         end
         ALU_BIT: begin
            fl = {(y[2:0] == 3'd7) && x[7], !x[y[2:0]], x[5], 1'b1, x[3],
                  !x[y[2:0]], 1'b0, fi[CARRY]};
         end
         ALU_RES, ALU_SET: r[7:0] = y[3] ? (x | mask) : (x & ~mask);
         default: ;
      endcase
      return {fl, r};
   endfunction

   assign {alu_f, alu_r} = alu_model(alu_m, alu_op1, alu_op2, f_ref);
   assign src_val   = regs[src_sel];
   assign mem_rdata = mem_rd ? mem_byte : 8'h00;
   assign mem_ready = (mem_rd && rd_cnt >= rd_wait) || (mem_wr && wr_cnt >= wr_wait);

   always @(posedge clock) begin
      rd_cnt <= mem_rd ? rd_cnt + 1 : 0;
      wr_cnt <= mem_wr ? wr_cnt + 1 : 0;
      if (mem_rd && mem_ready) last_raddr <= mem_addr;
      if (mem_wr && mem_ready) begin
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
         mem_wr_cnt <= mem_wr_cnt + 1;
      end
   end

   always @(negedge clock) begin
      if (done || wb_en || f_en) strobe_cnt  <= strobe_cnt + 1;
      if (mem_rd && mem_wr)      overlap_cnt <= overlap_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op and wait for done; A/F/HL are disturbed after start
   task automatic run(input logic c, input logic [7:0] op, input logic [7:0] im, output int cyc);
      @(negedge clock);
      cb = c; opcode = op; imm = im; start = 1'b1;
      @(negedge clock);
      start = 1'b0; cyc = 1;
      a = ~a; f = ~f; hl = ~hl;
      while (!done && cyc < 30) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   initial begin
      int cyc, snap, wsnap;
      reset = 1'b1; start = 1'b0; cb = 1'b0; opcode = 8'h00; imm = 8'h00;
      a = 8'h00; f = 8'h00; hl = 16'h0000; f_ref = 8'h00; mem_byte = 8'h00;
      rd_wait = 0; wr_wait = 0; n_checks = 0; n_errors = 0;
      for (int i = 0; i < 8; i++) regs[i] = 8'h00;
      repeat (2) @(negedge clock);

      check("rst_busy", busy, 0);
      check("rst_status", {done, illegal, wb_en, f_en}, 0);
      check("rst_mem", {mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
      check("rst_alu", {alu_m, alu_op1, alu_op2}, 0);
      check("rst_wb", {wb_sel, wb_data, f_out, src_sel}, 0);
      reset = 1'b0;

      // ADD A,B
      a = 8'h3A; regs[REG_B] = 8'hC6;
      run(1'b0, 8'h80, 8'h00, cyc);
      check("add_cyc", cyc, 2);
      check("add_wb", {wb_en, wb_sel, wb_data}, {1'b1, 3'd7, 8'h00});
      check("add_f", {f_en, f_out}, {1'b1, 8'h51});

      // CP B
      a = 8'h10; regs[REG_B] = 8'h20;
      run(1'b0, 8'hB8, 8'h00, cyc);
      check("cp_f", {f_en, f_out}, {1'b1, 8'hA3});
      check("cp_wben", wb_en, 0);

      // XOR A
      a = 8'h5A; regs[REG_A] = 8'h5A;
      run(1'b0, 8'hAF, 8'h00, cyc);
      check("xor_res", {wb_en, wb_data, f_out}, {1'b1, 8'h00, 8'h44});

      // ADD A,(HL), no wait states
      a = 8'h01; mem_byte = 8'h02; hl = 16'h4000; rd_wait = 0;
      run(1'b0, 8'h86, 8'h00, cyc);
      check("addhl_cyc", cyc, 3);
      check("addhl_res", {wb_data, f_out, last_raddr}, {8'h03, 8'h00, 16'h4000});

      // CB RLC B
      regs[REG_B] = 8'h81;
      run(1'b1, 8'h00, 8'h00, cyc);
      check("rlc_res", {wb_en, wb_sel, wb_data, f_en, f_out}, {1'b1, 3'd0, 8'h03, 1'b1, 8'h05});

      // CB SET 7,(HL) with two FETCH wait cycles
      hl = 16'h8000; mem_byte = 8'h01; rd_wait = 2; wr_wait = 0; wsnap = mem_wr_cnt;
      run(1'b1, 8'hFE, 8'h00, cyc);
      check("set_cyc", cyc, 6);
      check("set_rd", last_raddr, 16'h8000);
      check("set_wr", {last_waddr, last_wdata}, {16'h8000, 8'h81});
      check("set_nwr", mem_wr_cnt - wsnap, 1);
      check("set_en", {wb_en, f_en}, 0);
      rd_wait = 0;

      // CB BIT 0,C
      regs[REG_C] = 8'h00; f_ref = 8'h00;
      run(1'b1, 8'h41, 8'h00, cyc);
      check("bit_cyc", cyc, 2);
      check("bit_f", {f_en, f_out, wb_en}, {1'b1, 8'h54, 1'b0});

      // Reset during FETCH
      a = 8'h11; mem_byte = 8'h22; hl = 16'h1234; rd_wait = 5;
      @(negedge clock); cb = 1'b0; opcode = 8'h86; start = 1'b1;
      @(negedge clock); start = 1'b0;
      check("fetch_rd", mem_rd, 1);
      snap = strobe_cnt;
      #2 reset = 1'b1;
      #1;
      check("rst_async_rd", mem_rd, 0);
      check("rst_async_busy", busy, 0);
      @(negedge clock); reset = 1'b0; rd_wait = 0;
      repeat (4) @(negedge clock);
      check("rst_no_wb", strobe_cnt - snap, 0);
      a = 8'h01; regs[REG_B] = 8'h01;
      run(1'b0, 8'h80, 8'h00, cyc);
      check("post_rst_add", {cyc[3:0], wb_en, wb_data}, {4'd2, 1'b1, 8'h02});

      // Illegal opcode, then start during DONE must be dropped
      wsnap = mem_wr_cnt;
      run(1'b0, 8'h00, 8'h00, cyc);
      check("ill_cyc", cyc, 1);
      check("ill_status", {done, illegal, wb_en, f_en}, 4'b1100);
      opcode = 8'h80; start = 1'b1;
      @(negedge clock); start = 1'b0;
      check("start_in_done", busy, 0);
      check("ill_nomem", mem_wr_cnt - wsnap, 0);

      // Start held during EXEC is ignored
      a = 8'h05; regs[REG_C] = 8'h03;
      @(negedge clock); cb = 1'b0; opcode = 8'h81; start = 1'b1;
      @(negedge clock); opcode = 8'h00;
      @(negedge clock); start = 1'b0;
      check("busy_ign", {done, illegal, wb_data}, {1'b1, 1'b0, 8'h08});
      @(negedge clock);
      check("busy_ign_idle", busy, 0);

      // Immediate ALU op
      a = 8'hFF;
      run(1'b0, 8'hC6, 8'h01, cyc);
`ifdef ALU_CTL_IMM_EN
      check("imm_cyc", cyc, 2);
      check("imm_res", {illegal, wb_en, wb_data, f_out}, {1'b0, 1'b1, 8'h00, 8'h51});
`else
      check("imm_cyc", cyc, 1);
      check("imm_illegal", {illegal, wb_en, f_en}, 3'b100);
`endif

      check("no_rd_wr_overlap", overlap_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

`default_nettype wire
